// File: rtl/cfs_apb_pkg.sv
// Shared APB definitions for the APB master and the Aligner register block.
package cfs_apb_pkg;

   // Default bus widths, shared with the register block
   localparam int unsigned CFS_APB_ADDR_WIDTH = 16;
   localparam int unsigned CFS_APB_DATA_WIDTH = 32;

   // Transfer sequencing of the master
   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } cfs_apb_master_state_t;

   // Response returned to the requester (default data width)
   typedef struct packed {
      logic [CFS_APB_DATA_WIDTH-1:0] rdata;
      logic                          err;
      logic                          timeout;
   } cfs_apb_rsp_t;

endpackage

// File: rtl/cfs_apb_timer.sv
// Clearable saturating down-counter; done is high while the count is zero.
module cfs_apb_timer #(
   parameter int unsigned LOAD_VALUE = 15,
   parameter int unsigned CNT_W      = 5
) (
   input  logic pclk,
   input  logic presetn,
   input  logic clr,
   input  logic en,
   output logic done
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Reload on clear, otherwise count down and stick at zero
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = CNT_W'(LOAD_VALUE);
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Count register
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/cfs_apb_master.sv
// APB3 initiator: one request in, one response out, any number of wait states.
// Optional ACCESS timeout enabled by defining CFS_APB_MASTER_TIMEOUT_EN.
module cfs_apb_master
   import cfs_apb_pkg::*;
#(
   parameter int unsigned APB_ADDR_WIDTH = CFS_APB_ADDR_WIDTH,
   parameter int unsigned APB_DATA_WIDTH = CFS_APB_DATA_WIDTH,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                      pclk,
   input  logic                      presetn,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [APB_ADDR_WIDTH-1:0] req_addr,
   input  logic [APB_DATA_WIDTH-1:0] req_wdata,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
   output logic                      rsp_err,
   output logic                      rsp_timeout,
   output logic [APB_ADDR_WIDTH-1:0] paddr,
   output logic                      pwrite,
   output logic [APB_DATA_WIDTH-1:0] pwdata,
   output logic                      psel,
   output logic                      penable,
   input  logic                      pready,
   input  logic [APB_DATA_WIDTH-1:0] prdata,
   input  logic                      pslverr
);

   // Same layout as cfs_apb_rsp_t, sized by this instance's data width
   typedef struct packed {
      logic [APB_DATA_WIDTH-1:0] rdata;
      logic                      err;
      logic                      timeout;
   } rsp_t;

   cfs_apb_master_state_t     state_q, state_d;
   logic                      req_ready_q, req_ready_d;
   logic                      psel_q, psel_d;
   logic                      penable_q, penable_d;
   logic                      pwrite_q, pwrite_d;
   logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic                      rsp_valid_q, rsp_valid_d;
   rsp_t                      rsp_q, rsp_d;
   logic                      timeout_hit;

`ifdef CFS_APB_MASTER_TIMEOUT_EN
   localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

   logic tmr_done;

   // Loaded in SETUP with TIMEOUT_CYCLES-1 so it reads zero during the last allowed ACCESS cycle
   cfs_apb_timer #(
      .LOAD_VALUE (TIMEOUT_CYCLES - 1),
      .CNT_W      (TMR_W)
   ) u_timer (
      .pclk    (pclk),
      .presetn (presetn),
      .clr     (state_q == SETUP),
      .en      ((state_q == ACCESS) && !pready),
      .done    (tmr_done)
   );

   assign timeout_hit = (state_q == ACCESS) && !pready && tmr_done;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign timeout_hit        = 1'b0;
`endif

   // Next-state and next-output computation for the transfer FSM
   always_comb begin
      state_d     = state_q;
      req_ready_d = req_ready_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_d       = rsp_q;
      case (state_q)
         IDLE: begin
            req_ready_d = 1'b1;
            if (req_valid && req_ready_q) begin
               paddr_d     = req_addr;
               pwrite_d    = req_write;
               if (req_write) begin
                  pwdata_d = req_wdata;
               end
               psel_d      = 1'b1;
               req_ready_d = 1'b0;
               state_d     = SETUP;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            state_d   = ACCESS;
         end
         ACCESS: begin
            // A completing slave in the final cycle takes priority over the abort
            if (pready) begin
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_d.err     = pslverr;
               rsp_d.timeout = 1'b0;
               rsp_d.rdata   = (!pwrite_q && !pslverr) ? prdata : '0;
               rsp_valid_d   = 1'b1;
               state_d       = RESP;
            end else if (timeout_hit) begin
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_d.err     = 1'b1;
               rsp_d.timeout = 1'b1;
               rsp_d.rdata   = '0;
               rsp_valid_d   = 1'b1;
               state_d       = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d   = 1'b0;
               rsp_d.err     = 1'b0;
               rsp_d.timeout = 1'b0;
               req_ready_d   = 1'b1;
               state_d       = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_q       <= '0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_q       <= rsp_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign psel        = psel_q;
   assign penable     = penable_q;
   assign pwrite      = pwrite_q;
   assign paddr       = paddr_q;
   assign pwdata      = pwdata_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_q.rdata;
   assign rsp_err     = rsp_q.err;
   assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_cfs_apb_master.sv
// Self-checking bench for cfs_apb_master; define CFS_APB_MASTER_TIMEOUT_EN to cover the abort path.
module tb_cfs_apb_master;

   localparam int unsigned T = 16;

   logic        pclk = 1'b0;
   logic        presetn;
   logic        req_valid, req_ready, req_write;
   logic [15:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err, rsp_timeout;
   logic [15:0] paddr;
   logic        pwrite;
   logic [31:0] pwdata;
   logic        psel, penable;
   logic        pready;
   logic [31:0] prdata;
   logic        pslverr;

   int unsigned tests = 0;
   int unsigned fails = 0;
   logic [31:0] model_pwdata = '0;

   always #5 pclk = ~pclk;

   cfs_apb_master #(
      .APB_ADDR_WIDTH (16),
      .APB_DATA_WIDTH (32),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .pclk        (pclk),
      .presetn     (presetn),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .paddr       (paddr),
      .pwrite      (pwrite),
      .pwdata      (pwdata),
      .psel        (psel),
      .penable     (penable),
      .pready      (pready),
      .prdata      (prdata),
      .pslverr     (pslverr)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One complete transaction against a slave with `waits` wait states
   // (hang = slave never completes). Entered and left on a falling edge.
   task automatic xfer(input bit wr, input logic [15:0] addr, input logic [31:0] wd,
                       input int unsigned waits, input bit err, input logic [31:0] rd,
                       input bit hang, input int unsigned hold);
      int unsigned k, acc, psel_n, exp_k, exp_psel;
      bit          exp_err;
      logic [31:0] exp_rd;
      exp_err  = hang ? 1'b1 : err;
      exp_rd   = (!wr && !exp_err) ? rd : 32'h0;
      exp_k    = hang ? T + 2 : 3 + waits;
      exp_psel = hang ? T + 1 : 2 + waits;
      if (wr) model_pwdata = wd;

      chk("req_ready_before_accept", req_ready, 1);
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
      @(negedge pclk);
      req_valid = 1'b0; req_write = $urandom; req_addr = $urandom; req_wdata = $urandom;
      chk("penable_in_setup", penable, 0);

      k = 1; acc = 0; psel_n = 0;
      while (k < 60) begin
         if (psel) begin
            psel_n++;
            chk("paddr_stable", paddr, addr);
            chk("pwrite_stable", pwrite, wr);
            chk("pwdata_stable", pwdata, model_pwdata);
            chk("req_ready_busy", req_ready, 0);
         end
         if (k == 2) chk("penable_in_access", penable, 1);
         if (rsp_valid) break;
         if (psel && penable) begin
            acc++;
            pready = !hang && (acc > waits);
         end else begin
            pready = 1'b0;
         end
         prdata  = pready ? rd : $urandom;
         pslverr = pready ? err : 1'($urandom);
         @(negedge pclk);
         k++;
      end
      pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);

      chk("rsp_valid_seen", rsp_valid, 1);
      chk("rsp_latency", k, exp_k);
      chk("psel_cycles", psel_n, exp_psel);
      chk("rsp_err", rsp_err, exp_err);
      chk("rsp_timeout", rsp_timeout, hang);
      chk("rsp_rdata", rsp_rdata, exp_rd);
      chk("psel_in_resp", psel, 0);
      chk("penable_in_resp", penable, 0);

      for (int unsigned h = 0; h < hold; h++) begin
         rsp_ready = 1'b0;
         @(negedge pclk);
         chk("hold_rsp_valid", rsp_valid, 1);
         chk("hold_rsp_rdata", rsp_rdata, exp_rd);
         chk("hold_rsp_err", rsp_err, exp_err);
         chk("hold_rsp_timeout", rsp_timeout, hang);
         chk("hold_req_ready", req_ready, 0);
         chk("hold_psel", psel, 0);
      end
      rsp_ready = 1'b1;
      @(negedge pclk);
      rsp_ready = 1'b0;
      chk("consumed_rsp_valid", rsp_valid, 0);
      chk("consumed_rsp_err", rsp_err, 0);
      chk("consumed_rsp_timeout", rsp_timeout, 0);
      chk("consumed_req_ready", req_ready, 1);
      chk("idle_paddr_kept", paddr, addr);
      chk("idle_pwdata_kept", pwdata, model_pwdata);
   endtask

   initial begin
      presetn   = 1'b0;
      req_valid = 1'b1;     // presented during reset: must not be taken
      req_write = 1'b0;
      req_addr  = 16'h0010;
      req_wdata = 32'h0;
      rsp_ready = 1'b0;
      pready    = 1'b0;
      prdata    = '0;
      pslverr   = 1'b0;

      // Reset state
      repeat (3) @(negedge pclk);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_psel", psel, 0);
      chk("rst_penable", penable, 0);
      chk("rst_pwrite", pwrite, 0);
      chk("rst_paddr", paddr, 0);
      chk("rst_pwdata", pwdata, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rsp_timeout", rsp_timeout, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      presetn = 1'b1;
      @(negedge pclk);
      chk("first_edge_req_ready", req_ready, 1);
      chk("no_accept_on_first_edge", psel, 0);
      req_valid = 1'b0;

      // Directed register-block scenarios
      xfer(1'b0, 16'h0000, 32'h0, 1, 1'b0, 32'h0000_0001, 1'b0, 0);
      xfer(1'b1, 16'h000C, 32'hFFFF_FFFF, 1, 1'b1, 32'hDEAD_BEEF, 1'b0, 0);
      xfer(1'b1, 16'h0000, 32'h0000_0000, 2, 1'b1, 32'h1234_5678, 1'b0, 0);
      xfer(1'b0, 16'h0004, 32'h0, 0, 1'b0, 32'hA5A5_5A5A, 1'b0, 0);
      xfer(1'b0, 16'h0008, 32'h0, T - 1, 1'b0, 32'h0BAD_F00D, 1'b0, 1);
`ifdef CFS_APB_MASTER_TIMEOUT_EN
      xfer(1'b0, 16'h0020, 32'h0, 0, 1'b0, 32'hFFFF_FFFF, 1'b1, 0);
      xfer(1'b0, 16'h00F0, 32'h0, 1, 1'b0, 32'h0000_001F, 1'b0, 0);
      xfer(1'b1, 16'h0024, 32'hCAFE_0001, 0, 1'b0, 32'h0, 1'b1, 2);
`endif
      // Response backpressure
      xfer(1'b1, 16'h0014, 32'h1357_9BDF, 1, 1'b0, 32'h5555_AAAA, 1'b0, 5);

      // Randomized traffic
      for (int i = 0; i < 25; i++) begin
         xfer(1'($urandom), 16'($urandom), $urandom, $urandom_range(0, 4),
              ($urandom_range(0, 3) == 0), $urandom, 1'b0, $urandom_range(0, 3));
      end

      // Reset in the middle of ACCESS
      req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0018;
      @(negedge pclk);
      req_valid = 1'b0;
      pready = 1'b0;
      for (int i = 0; i < 4 && !penable; i++) @(negedge pclk);
      chk("midrst_penable_before", penable, 1);
      #2 presetn = 1'b0;
      #1;
      chk("midrst_psel", psel, 0);
      chk("midrst_penable", penable, 0);
      chk("midrst_rsp_valid", rsp_valid, 0);
      chk("midrst_req_ready", req_ready, 0);
      model_pwdata = '0;
      @(negedge pclk);
      presetn = 1'b1;
      @(negedge pclk);
      chk("midrst_release_req_ready", req_ready, 1);
      chk("midrst_release_psel", psel, 0);
      chk("midrst_release_rsp_valid", rsp_valid, 0);
      xfer(1'b0, 16'h0000, 32'h0, 1, 1'b0, 32'h0000_0001, 1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
